zbus_dec: RTL and testbench

ZBUS_DEC -- requirements
Module: zbus_dec

---
 rtl/zbus_dec_pkg.sv | 53 +++++
 rtl/zbus_dec_sync2.sv | 29 ++
 rtl/zbus_dec.sv | 190 +++++++++++++++++++
 tb/tb_zbus_dec.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/zbus_dec_pkg.sv
// Shared constants and helpers for the Z80 I/O port decoder (#FFFD / #BFFD).
package zbus_dec_pkg;

  // Decoder FSM states.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_QUAL = 2'd1;
  localparam logic [1:0] ST_FIRE = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  // Decoded address bits are packed as {a15, a14, a1}.
  localparam int unsigned ADDR_W  = 3;
  localparam int          ADR_A15 = 2;
  localparam int          ADR_A14 = 1;
  localparam int          ADR_A1  = 0;

  localparam logic [ADDR_W-1:0] PORT_FFFD   = 3'b110;
  localparam logic [ADDR_W-1:0] PORT_BFFD   = 3'b100;
  // Writes decode both ports (a14 selects the target later); reads only #FFFD.
  localparam logic [ADDR_W-1:0] WR_DEC_MASK = 3'b101;
  localparam logic [ADDR_W-1:0] RD_DEC_MASK = 3'b111;

  // Data prefix that turns a #FFFD write into a config-latch write.
  localparam logic [4:0] CFG_PREFIX = 5'b11111;

  // Control bits are packed as {iorq_n, wr_n, rd_n, m1_n}; all inactive high.
  localparam int unsigned CTRL_W        = 4;
  localparam int          CTRL_IORQ     = 3;
  localparam int          CTRL_WR       = 2;
  localparam int          CTRL_RD       = 1;
  localparam int          CTRL_M1       = 0;
  localparam logic [CTRL_W-1:0] CTRL_INACTIVE = 4'b1111;

  typedef enum logic [1:0] {
    WK_CFG,
    WK_YM_ADDR,
    WK_YM_DATA
  } wr_kind_e;

  // True when the masked address bits equal the masked port pattern.
  function automatic logic port_hit(input logic [ADDR_W-1:0] addr,
                                    input logic [ADDR_W-1:0] mask,
                                    input logic [ADDR_W-1:0] port);
    return ((addr ^ port) & mask) == '0;
  endfunction

  // Select which strobe an accepted write produces.
  function automatic wr_kind_e classify_write(input logic a14, input logic [7:0] data);
    if (!a14) return WK_YM_DATA;
    if (data[7:3] == CFG_PREFIX) return WK_CFG;
    return WK_YM_ADDR;
  endfunction

endpackage

// File: rtl/zbus_dec_sync2.sv
// Two-flop synchronizer for a bundle of asynchronous inputs, with a
// configurable reset value so that inactive bus levels are seen during reset.
module zbus_dec_sync2 #(
  parameter int unsigned           WIDTH   = 1,
  parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // First stage may go metastable; only the second stage is used downstream.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/zbus_dec.sv
// Z80 I/O decoder for the YM / config ports: synchronizes the raw bus,
// qualifies a write or read over FILT samples, then emits one strobe per
// bus cycle (writes) or holds rd_fffd for the rest of the cycle (reads).
module zbus_dec
  import zbus_dec_pkg::*;
#(
  parameter int FILT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iorq_n,
  input  logic       wr_n,
  input  logic       rd_n,
  input  logic       m1_n,
  input  logic       a15,
  input  logic       a14,
  input  logic       a1,
  input  logic [7:0] zd,
  output logic [7:0] d,
  output logic       cfg_wrstb,
  output logic       ym_addr_wrstb,
  output logic       ym_data_wrstb,
  output logic       rd_fffd
);

  localparam logic [2:0] FILT_M1 = 3'(FILT - 1);

  logic [CTRL_W-1:0] ctrl_s;
  logic [ADDR_W-1:0] addr_s;
  logic [7:0]        data_s;

  logic iorq_s, wr_s, rd_s, m1_s;
  logic wr_cond, rd_cond, qual_cond;
  wr_kind_e fire_kind;

  logic [1:0] sync_vld_q;
  logic       armed_q;

  logic [1:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       is_wr_q, is_wr_d;
  logic [7:0] d_q, d_d;
  logic       cfg_q, cfg_d;
  logic       yma_q, yma_d;
  logic       ymd_q, ymd_d;
  logic       rd_q, rd_d;

  zbus_dec_sync2 #(
    .WIDTH  (CTRL_W),
    .RST_VAL(CTRL_INACTIVE)
  ) u_sync_ctrl (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .async_i({iorq_n, wr_n, rd_n, m1_n}),
    .sync_o (ctrl_s)
  );

  zbus_dec_sync2 #(
    .WIDTH  (ADDR_W),
    .RST_VAL('0)
  ) u_sync_addr (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .async_i({a15, a14, a1}),
    .sync_o (addr_s)
  );

  zbus_dec_sync2 #(
    .WIDTH  (8),
    .RST_VAL('0)
  ) u_sync_data (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .async_i(zd),
    .sync_o (data_s)
  );

  assign iorq_s = ctrl_s[CTRL_IORQ];
  assign wr_s   = ctrl_s[CTRL_WR];
  assign rd_s   = ctrl_s[CTRL_RD];
  assign m1_s   = ctrl_s[CTRL_M1];

  // m1_s high excludes interrupt acknowledge; a write wins over a read when
  // both strobes are (illegally) low together.
  assign wr_cond = !iorq_s && !wr_s && m1_s &&
                   (port_hit(addr_s, WR_DEC_MASK, PORT_FFFD) ||
                    port_hit(addr_s, WR_DEC_MASK, PORT_BFFD));
  assign rd_cond = !iorq_s && !rd_s && m1_s && !wr_cond &&
                   port_hit(addr_s, RD_DEC_MASK, PORT_FFFD);
  assign qual_cond = is_wr_q ? wr_cond : rd_cond;
  assign fire_kind = classify_write(addr_s[ADR_A14], data_s);

  // Track when the second synchronizer stage holds a real bus sample, and
  // refuse new cycles after reset until iorq_n has been seen high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_vld_q <= 2'b00;
      armed_q    <= 1'b0;
    end else begin
      sync_vld_q <= {sync_vld_q[0], 1'b1};
      if (sync_vld_q[1] && iorq_s) begin
        armed_q <= 1'b1;
      end
    end
  end

  // Next-state logic: qualify, fire once, then hold until the cycle ends.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    is_wr_d = is_wr_q;
    d_d     = d_q;
    cfg_d   = 1'b0;
    yma_d   = 1'b0;
    ymd_d   = 1'b0;
    rd_d    = rd_q;
    unique case (state_q)
      ST_IDLE: begin
        if (armed_q && (wr_cond || rd_cond)) begin
          is_wr_d = wr_cond;
          cnt_d   = 3'd0;
          state_d = (FILT <= 1) ? ST_FIRE : ST_QUAL;
        end
      end
      ST_QUAL: begin
        if (qual_cond) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_d == FILT_M1) begin
            state_d = ST_FIRE;
          end
        end else begin
          cnt_d   = 3'd0;
          state_d = ST_IDLE;
        end
      end
      ST_FIRE: begin
        cnt_d   = 3'd0;
        state_d = ST_HOLD;
        if (is_wr_q) begin
          d_d   = data_s;
          cfg_d = (fire_kind == WK_CFG);
          yma_d = (fire_kind == WK_YM_ADDR);
          ymd_d = (fire_kind == WK_YM_DATA);
        end else begin
          rd_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (iorq_s) begin
          rd_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        rd_d    = 1'b0;
      end
    endcase
  end

  // FSM, latched data and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      is_wr_q <= 1'b0;
      d_q     <= 8'h00;
      cfg_q   <= 1'b0;
      yma_q   <= 1'b0;
      ymd_q   <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is_wr_q <= is_wr_d;
      d_q     <= d_d;
      cfg_q   <= cfg_d;
      yma_q   <= yma_d;
      ymd_q   <= ymd_d;
      rd_q    <= rd_d;
    end
  end

  assign d             = d_q;
  assign cfg_wrstb     = cfg_q;
  assign ym_addr_wrstb = yma_q;
  assign ym_data_wrstb = ymd_q;
  assign rd_fffd       = rd_q;

endmodule

// File: tb/tb_zbus_dec.sv
// Testbench for zbus_dec: directed bus cycles with literal expectations plus
// randomized bus traffic, all compared each cycle against a run-length model.
module tb_zbus_dec;

  localparam int FILT = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       iorq_n = 1'b1, wr_n = 1'b1, rd_n = 1'b1, m1_n = 1'b1;
  logic       a15 = 1'b0, a14 = 1'b0, a1 = 1'b0;
  logic [7:0] zd = 8'h00;
  logic [7:0] d;
  logic       cfg_wrstb, ym_addr_wrstb, ym_data_wrstb, rd_fffd;

  int total = 0;
  int bad   = 0;

  zbus_dec #(.FILT(FILT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .iorq_n       (iorq_n),
    .wr_n         (wr_n),
    .rd_n         (rd_n),
    .m1_n         (m1_n),
    .a15          (a15),
    .a14          (a14),
    .a1           (a1),
    .zd           (zd),
    .d            (d),
    .cfg_wrstb    (cfg_wrstb),
    .ym_addr_wrstb(ym_addr_wrstb),
    .ym_data_wrstb(ym_data_wrstb),
    .rd_fffd      (rd_fffd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A bus sample reaches the decoder two clocks after it is captured. A write
  // or read is accepted after FILT consecutive qualifying samples of the same
  // kind; the following sample decides the write target / raises rd_fffd, and
  // nothing more happens until a sample with iorq_n high ends the bus cycle.
  logic [14:0] hist[$];
  bit          armed_m = 0;
  int          run_m = 0;
  int          rkind_m = 0;
  int          phase_m = 0;
  logic [7:0]  exp_d = 8'h00;
  bit          exp_cfg = 0, exp_yma = 0, exp_ymd = 0, exp_rd = 0;

  task automatic model_step(input logic [14:0] s);
    // s = {iorq_n, wr_n, rd_n, m1_n, a15, a14, a1, zd}
    bit w, r;
    int k;
    w = !s[14] && !s[13] && s[11] && s[10] && !s[8];
    r = !s[14] && !s[12] && s[11] && s[10] && s[9] && !s[8];
    k = w ? 1 : (r ? 2 : 0);
    if (!armed_m) begin
      if (s[14]) armed_m = 1;
      return;
    end
    case (phase_m)
      0: begin
        if (run_m > 0) begin
          if (k == rkind_m) run_m++;
          else run_m = 0;
        end else if (k != 0) begin
          run_m   = 1;
          rkind_m = k;
        end
        if (run_m == FILT) begin
          phase_m = 1;
          run_m   = 0;
        end
      end
      1: begin
        if (rkind_m == 1) begin
          exp_d = s[7:0];
          if (s[9] && s[7:3] == 5'b11111) exp_cfg = 1;
          else if (s[9]) exp_yma = 1;
          else exp_ymd = 1;
        end else begin
          exp_rd = 1;
        end
        phase_m = 2;
      end
      default: begin
        if (s[14]) begin
          exp_rd  = 0;
          phase_m = 0;
        end
      end
    endcase
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      hist.delete();
      armed_m = 0; run_m = 0; rkind_m = 0; phase_m = 0;
      exp_d = 8'h00; exp_cfg = 0; exp_yma = 0; exp_ymd = 0; exp_rd = 0;
    end else begin
      exp_cfg = 0; exp_yma = 0; exp_ymd = 0;
      if (hist.size() >= 2) model_step(hist[hist.size()-2]);
      hist.push_back({iorq_n, wr_n, rd_n, m1_n, a15, a14, a1, zd});
      if (hist.size() > 2) void'(hist.pop_front());
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial forever begin
    @(negedge clk);
    chk("outputs{d,cfg,yma,ymd,rd}",
        32'({d, cfg_wrstb, ym_addr_wrstb, ym_data_wrstb, rd_fffd}),
        32'({exp_d, exp_cfg, exp_yma, exp_ymd, exp_rd}));
  end

  // ---------------- stimulus ----------------
  // Drives one bus cycle starting at a falling clk edge, holds it for len
  // clocks, then observes 6 more clocks. Offsets count rising edges from start.
  task automatic bus_cycle(input bit do_wr, input bit do_rd, input bit inta,
                           input bit va15, input bit va14, input bit va1,
                           input logic [7:0] dv, input int len,
                           output int ncfg, output int nyma, output int nymd,
                           output int first, output int rfirst, output int rlast,
                           output logic [7:0] dat);
    ncfg = 0; nyma = 0; nymd = 0; first = -1; rfirst = -1; rlast = -1; dat = 8'h00;
    a15 = va15; a14 = va14; a1 = va1; zd = dv;
    m1_n = !inta; iorq_n = 1'b0; wr_n = !do_wr; rd_n = !do_rd;
    for (int off = 1; off <= len + 6; off++) begin
      @(negedge clk);
      if (cfg_wrstb)     begin ncfg++; if (first < 0) first = off; dat = d; end
      if (ym_addr_wrstb) begin nyma++; if (first < 0) first = off; dat = d; end
      if (ym_data_wrstb) begin nymd++; if (first < 0) first = off; dat = d; end
      if (rd_fffd) begin
        if (rfirst < 0) rfirst = off;
        rlast = off;
      end
      if (off == len) begin
        iorq_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1; m1_n = 1'b1;
      end
    end
  endtask

  initial begin
    int nc, na, nd, fo, rf, rl, strobes, kind, len;
    logic [7:0] dat;

    repeat (2) @(negedge clk);
    chk("reset_d", 32'(d), 32'h00);
    chk("reset_outs", 32'({cfg_wrstb, ym_addr_wrstb, ym_data_wrstb, rd_fffd}), 32'h0);
    #2 rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // Config write #FFFD, data F9.
    bus_cycle(1, 0, 0, 1, 1, 0, 8'hF9, 10, nc, na, nd, fo, rf, rl, dat);
    chk("cfg_count", nc, 1);
    chk("cfg_latency", fo, FILT + 3);
    chk("cfg_data", 32'(dat), 32'hF9);
    chk("cfg_other_strobes", na + nd, 0);
    chk("cfg_no_rd", rf, -1);

    // YM address then YM data.
    bus_cycle(1, 0, 0, 1, 1, 0, 8'h07, 6, nc, na, nd, fo, rf, rl, dat);
    chk("yma_count", na, 1);
    chk("yma_data", 32'(dat), 32'h07);
    chk("yma_others", nc + nd, 0);
    bus_cycle(1, 0, 0, 1, 0, 0, 8'h3C, 6, nc, na, nd, fo, rf, rl, dat);
    chk("ymd_count", nd, 1);
    chk("ymd_data", 32'(dat), 32'h3C);
    chk("ymd_latency", fo, FILT + 3);

    // One-clock glitch never qualifies.
    bus_cycle(1, 0, 0, 1, 1, 0, 8'hF9, 1, nc, na, nd, fo, rf, rl, dat);
    chk("glitch_strobes", nc + na + nd, 0);

    // Interrupt acknowledge with a read pattern on #FFFD.
    bus_cycle(0, 1, 1, 1, 1, 0, 8'hAA, 8, nc, na, nd, fo, rf, rl, dat);
    chk("inta_strobes", nc + na + nd, 0);
    chk("inta_rd", rf, -1);

    // Read #FFFD for 8 clocks.
    bus_cycle(0, 1, 0, 1, 1, 0, 8'h55, 8, nc, na, nd, fo, rf, rl, dat);
    chk("rd_first", rf, FILT + 3);
    chk("rd_last", rl, 8 + 2);
    chk("rd_strobes", nc + na + nd, 0);
    chk("rd_d_kept", 32'(d), 32'h3C);

    // Write and read together is a write.
    bus_cycle(1, 1, 0, 1, 1, 0, 8'h21, 6, nc, na, nd, fo, rf, rl, dat);
    chk("wr_rd_yma", na, 1);
    chk("wr_rd_no_rd", rf, -1);

    // Reset pulse in the middle of a write, released while iorq_n still low.
    strobes = 0;
    a15 = 1'b1; a14 = 1'b1; a1 = 1'b0; zd = 8'hF9; m1_n = 1'b1; iorq_n = 1'b0; wr_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      strobes += int'(cfg_wrstb) + int'(ym_addr_wrstb) + int'(ym_data_wrstb);
      if (i == 9) begin iorq_n = 1'b1; wr_n = 1'b1; end
    end
    chk("rst_mid_strobes", strobes, 0);
    bus_cycle(1, 0, 0, 1, 1, 0, 8'hFF, 6, nc, na, nd, fo, rf, rl, dat);
    chk("post_rst_cfg", nc, 1);
    chk("post_rst_latency", fo, FILT + 3);

    // Randomized traffic, checked only by the per-cycle model comparison.
    for (int n = 0; n < 400; n++) begin
      kind   = int'($urandom_range(0, 5));
      len    = int'($urandom_range(1, 10));
      a15    = ($urandom_range(0, 3) != 0);
      a14    = 1'($urandom);
      a1     = ($urandom_range(0, 3) == 0);
      zd     = 8'($urandom);
      if ($urandom_range(0, 1) == 0) zd[7:3] = 5'b11111;
      m1_n   = ($urandom_range(0, 7) != 0);
      iorq_n = 1'b0;
      wr_n   = !(kind <= 2 || kind == 5);
      rd_n   = !(kind == 3 || kind == 4 || kind == 5);
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        if ($urandom_range(0, 15) == 0) wr_n = ~wr_n;
        if ($urandom_range(0, 15) == 0) rd_n = ~rd_n;
        if ($urandom_range(0, 19) == 0) iorq_n = ~iorq_n;
        if ($urandom_range(0, 15) == 0) zd = 8'($urandom);
      end
      if ($urandom_range(0, 49) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
      iorq_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1; m1_n = 1'b1;
      repeat (int'($urandom_range(1, 4))) @(negedge clk);
    end

    repeat (8) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
